// File: rtl/mini_cpu_pkg.sv
// Shared mini-cpu definitions: fetch FSM states and common constants.
package mini_cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned TMO_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    RESOLVE,
    HALTED,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout.sv
// Saturating cycle counter for bounding how long a fetch may wait for imem_ack.
module fetch_timeout
  import mini_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT);

  logic [TMO_W-1:0] count_q;
  logic [TMO_W-1:0] count_d;

  // Clear wins over enable; count sticks at the limit once reached.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + TMO_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue/resolve control FSM: one pc update per retired instruction.
module fetch_sequencer #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned INSTR_W = mini_cpu_pkg::INSTR_W,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    pc,
  output logic               pc_advance,
  output logic               pc_src,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic               imem_err,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  input  logic               instr_ready,
  input  logic               branch_valid,
  input  logic               branch_taken,
  input  logic               halt_req,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   instret
);

  import mini_cpu_pkg::*;

  fetch_state_t       state_q;
  fetch_state_t       state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] instr_d;
  logic [CNT_W-1:0]   instret_q;
  logic [CNT_W-1:0]   instret_d;

  logic in_fetch;
  logic retire;
  logic tmo_expired;

  assign in_fetch = (state_q == FETCH);
  assign retire   = (state_q == RESOLVE) && branch_valid;

  fetch_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_fetch),
    .enable (in_fetch && !imem_ack),
    .expired(tmo_expired)
  );

  // Next state, instruction latch and retire counter.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          if (imem_err) begin
            state_d = FAULT;
          end else begin
            instr_d = imem_rdata;
            state_d = ISSUE;
          end
        end else if (tmo_expired) begin
          state_d = FAULT;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (branch_valid) begin
          instret_d = instret_q + CNT_W'(1);
          state_d   = halt_req ? HALTED : FETCH;
        end
      end
      HALTED, FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  // Outputs decoded from state; pc_advance/pc_src qualify the resolving cycle.
  assign imem_req    = in_fetch;
  assign imem_addr   = in_fetch ? pc : '0;
  assign instr_valid = (state_q == ISSUE);
  assign instr       = instr_q;
  assign pc_advance  = retire;
  assign pc_src      = (state_q == RESOLVE) && branch_taken;
  assign halted      = (state_q == HALTED);
  assign fault       = (state_q == FAULT);
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a transaction-level pc model.
module tb_fetch_sequencer;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 32;

  logic               clk;
  logic               rst;
  logic [XLEN-1:0]    pc;
  logic               pc_advance;
  logic               pc_src;
  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_ack;
  logic               imem_err;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic               branch_valid;
  logic               branch_taken;
  logic               halt_req;
  logic               halted;
  logic               fault;
  logic [CNT_W-1:0]   instret;

  logic [XLEN-1:0]    br_imm;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int last_ret_cyc = 0;

  // Reference model state (instruction-level).
  logic [63:0] model_pc;
  logic [31:0] model_instret;
  logic [31:0] last_instr;

  logic [63:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  bit          exp_src_q[$];
  logic [31:0] exp_instret_q[$];

  fetch_sequencer #(
    .XLEN(XLEN), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_advance(pc_advance), .pc_src(pc_src),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_err(imem_err), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_ready(instr_ready), .branch_valid(branch_valid),
    .branch_taken(branch_taken), .halt_req(halt_req), .halted(halted),
    .fault(fault), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Environment program counter register driven by the DUT's update commands.
  always @(posedge clk) begin
    if (rst) pc <= '0;
    else if (pc_advance) pc <= pc_src ? pc + br_imm : pc + 64'd4;
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail_evt(string name);
    n_total++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endfunction

  // Monitor: pops expectations whenever the DUT presents an observable event.
  logic        req_prev = 1'b0;
  logic        adv_prev = 1'b0;
  logic [63:0] addr_hold = '0;
  always @(negedge clk) begin
    if (rst) begin
      req_prev = 1'b0;
      adv_prev = 1'b0;
    end else begin
      if (imem_req && !req_prev) begin
        if (exp_addr_q.size() == 0) fail_evt("fetch_start");
        else check("fetch_addr", imem_addr, exp_addr_q.pop_front());
        addr_hold = imem_addr;
      end else if (imem_req) begin
        check("fetch_addr_stable", imem_addr, addr_hold);
      end else begin
        check("addr_zero_outside_fetch", imem_addr, 64'd0);
      end
      if (instr_valid && instr_ready) begin
        if (exp_instr_q.size() == 0) fail_evt("issue");
        else check("issued_instr", 64'(instr), 64'(exp_instr_q.pop_front()));
      end
      if (pc_advance) begin
        check("advance_with_resolution", 64'(branch_valid), 64'(1));
        if (exp_src_q.size() == 0) fail_evt("pc_advance");
        else check("pc_src", 64'(pc_src), 64'(exp_src_q.pop_front()));
      end
      if (adv_prev) begin
        if (exp_instret_q.size() == 0) fail_evt("instret_update");
        else check("instret", 64'(instret), 64'(exp_instret_q.pop_front()));
      end
      req_prev = imem_req;
      adv_prev = pc_advance;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; branch_valid = 1'b0; branch_taken = 1'b0;
    halt_req = 1'b0; br_imm = '0;
  endtask

  task automatic noise(input bit en, input bit allow_bv, input bit allow_rdy);
    if (en) begin
      halt_req     = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      if (allow_bv)  branch_valid = 1'($urandom_range(0, 1));
      if (allow_rdy) instr_ready  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_imem_addr", imem_addr, 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_pc_advance", 64'(pc_advance), 64'd0);
    check("rst_pc_src", 64'(pc_src), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_instret", 64'(instret), 64'd0);
    step();
    exp_addr_q.delete(); exp_instr_q.delete(); exp_src_q.delete(); exp_instret_q.delete();
    model_pc = '0; model_instret = '0; last_instr = '0;
    rst = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    ok = (imem_req === 1'b1);
    if (!ok) $display("FAIL fetch_wait: imem_req=%b after %0d cycles, required 1", imem_req, n);
    if (!ok) n_total++;
  endtask

  // One instruction through fetch, issue and resolve.
  task automatic run_instr(input int wait_ack, input int ready_dly, input int br_dly,
                           input bit taken, input logic [63:0] imm, input bit halt,
                           input bit err, input bit nz, input logic [31:0] word);
    bit ok;
    exp_addr_q.push_back(model_pc);
    wait_req(ok);
    if (!ok) return;
    for (int i = 0; i < wait_ack; i++) begin
      noise(nz, 1'b1, 1'b1);
      check("fetch_req_held", 64'(imem_req), 64'd1);
      step();
    end
    noise(nz, 1'b1, 1'b1);
    imem_ack = 1'b1; imem_err = err; imem_rdata = word;
    if (!err) exp_instr_q.push_back(word);
    step();
    imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = $urandom;
    if (err) begin
      clear_inputs();
      check("fault_on_err", 64'(fault), 64'd1);
      check("instr_hold_on_err", 64'(instr), 64'(last_instr));
      return;
    end
    last_instr = word;
    for (int i = 0; i < ready_dly; i++) begin
      instr_ready = 1'b0;
      noise(nz, 1'b1, 1'b0);
      check("valid_held", 64'(instr_valid), 64'd1);
      step();
    end
    noise(nz, 1'b1, 1'b0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < br_dly; i++) begin
      branch_valid = 1'b0;
      noise(nz, 1'b0, 1'b1);
      step();
    end
    noise(nz, 1'b0, 1'b1);
    branch_valid = 1'b1; branch_taken = taken; br_imm = imm; halt_req = halt;
    exp_src_q.push_back(taken);
    model_instret = model_instret + 32'd1;
    exp_instret_q.push_back(model_instret);
    model_pc = taken ? model_pc + imm : model_pc + 64'd4;
    step();
    last_ret_cyc = cyc;
    clear_inputs();
  endtask

  task automatic run_timeout();
    bit ok;
    exp_addr_q.push_back(model_pc);
    wait_req(ok);
    if (!ok) return;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      step();
      check("tmo_still_fetching", 64'(imem_req), 64'd1);
      check("tmo_no_fault_yet", 64'(fault), 64'd0);
    end
    step();
    check("tmo_fault", 64'(fault), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fault_no_req", 64'(imem_req), 64'd0);
      check("fault_sticky", 64'(fault), 64'd1);
    end
  endtask

  initial begin
    int prev_ret;
    bit ok;
    logic [63:0] imm;
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Zero-wait straight-line: addresses 0,4,8,12, one retire every 3 cycles.
    for (int k = 0; k < 4; k++) begin
      prev_ret = last_ret_cyc;
      run_instr(0, 0, 0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, $urandom);
      if (k > 0) check("retire_spacing", 64'(last_ret_cyc - prev_ret), 64'd3);
    end
    check("instret_after_4", 64'(instret), 64'd4);

    // Fetch wait states with a known word, then a bus error.
    run_instr(5, 0, 2, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 32'h0050_0093);
    check("instr_known_word", 64'(instr), 64'h0050_0093);
    run_instr(0, 0, 0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 3; i++) begin
      step();
      check("err_fault_sticky", 64'(fault), 64'd1);
      check("err_no_req", 64'(imem_req), 64'd0);
    end

    // Branches with backpressure, then halt at pc=12.
    do_reset();
    run_instr(0, 0, 0, 1'b1, 64'd68, 1'b0, 1'b0, 1'b0, $urandom);
    check("pc_after_branch_68", pc, 64'd68);
    run_instr(0, 3, 0, 1'b1, -64'sd64, 1'b0, 1'b0, 1'b0, $urandom);
    run_instr(0, 0, 0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, $urandom);
    run_instr(0, 0, 0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, $urandom);
    run_instr(0, 0, 1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, $urandom);
    for (int i = 0; i < 4; i++) begin
      check("halted", 64'(halted), 64'd1);
      check("halted_no_req", 64'(imem_req), 64'd0);
      check("halted_pc_frozen", pc, 64'd16);
      step();
    end

    // Reset out of HALTED, then fetch timeout.
    do_reset();
    run_timeout();

    // Reset in the middle of a fetch.
    do_reset();
    run_instr(1, 1, 1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, $urandom);
    exp_addr_q.push_back(model_pc);
    wait_req(ok);
    step();
    step();
    do_reset();
    run_instr(0, 0, 0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, $urandom);

    // Randomised run with input noise outside the owning states.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      imm = 64'(longint'(int'($urandom_range(0, 32)) - 16) * 4);
      run_instr((k == 10) ? int'(TIMEOUT) : int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), imm, (k == 59), 1'b0, 1'b1, $urandom);
    end
    step();
    check("rand_halted", 64'(halted), 64'd1);
    check("rand_instret", 64'(instret), 64'(model_instret));
    check("rand_pc", pc, model_pc);
    step();
    check("queues_drained", 64'(exp_addr_q.size() + exp_instr_q.size() +
                                exp_src_q.size() + exp_instret_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle control FSM that sequences the mini-cpu program counter through fetch, issue and branch resolution. It issues an instruction-memory request at the current pc and hands the fetched word to decode with a valid/ready handshake. It then waits for execute's branch resolution and commands exactly one program counter update per instruction: pc+4, or the branch target. Sits between program_counter, instruction memory and the decode/execute stages; the program counter register itself lives outside this block.

Parameters:
XLEN, 64, width of pc and instruction address
INSTR_W, 32, instruction word width
TIMEOUT, 15, max cycles in FETCH waiting for imem_ack before FAULT (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
pc  in  XLEN  current value from program counter
pc_advance  out  1  one-cycle enable: program counter updates on this edge
pc_src  out  1  0 = pc+4, 1 = branch target; meaningful only with pc_advance
imem_req  out  1  instruction fetch request, held until ack
imem_addr  out  XLEN  fetch address
imem_ack  in  1  fetch complete, imem_rdata valid this cycle
imem_err  in  1  bus error; qualifies imem_ack
imem_rdata  in  INSTR_W  fetched word
instr_valid  out  1  instruction available to decode
instr  out  INSTR_W  latched instruction
instr_ready  in  1  decode accepts
branch_valid  in  1  execute has resolved the issued instruction
branch_taken  in  1  taken flag, sampled with branch_valid
halt_req  in  1  stop after current instruction retires
halted  out  1  in HALTED
fault  out  1  in FAULT
instret  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, ISSUE, RESOLVE, HALTED, FAULT. Moore outputs decoded from state, except pc_src, which is a combinational copy of branch_taken in RESOLVE.
- rst=1 at an edge: state goes to IDLE, instr=0, instret=0, timeout counter=0. rst has priority over every other input and applies in any state, including mid-fetch. While in IDLE all outputs are 0.
- IDLE -> FETCH unconditionally on the next edge after rst=0.
- FETCH: imem_req=1, imem_addr=pc; imem_addr=0 in all other states.
  - imem_ack=1 & imem_err=0: latch imem_rdata into instr, go to ISSUE. Ack in the first FETCH cycle is legal.
  - imem_ack=1 & imem_err=1: go to FAULT.
  - Timeout counter increments each FETCH cycle without ack and clears on leaving FETCH. When it reaches TIMEOUT, the next non-ack cycle goes to FAULT.
- ISSUE: instr_valid=1, instr stable. On instr_ready=1, go to RESOLVE. Valid is never withdrawn before ready.
- RESOLVE: wait for branch_valid. When branch_valid=1:
  - pc_advance=1 for exactly that cycle; pc_src=branch_taken.
  - instret increments, wrapping modulo 2^CNT_W.
  - Next state is HALTED if halt_req=1 that cycle, else FETCH.
- pc_advance is never asserted outside RESOLVE, so there is exactly one pc update per retired instruction. Zero-wait throughput is 3 cycles per instruction.
- branch_valid and instr_ready outside their states are ignored.
- halt_req outside RESOLVE has no effect. Halt is taken only at a retire boundary.
- HALTED: halted=1, no requests, pc frozen. Exit only via rst.
- FAULT: fault=1, no requests, pc frozen. Exit only via rst.
- imem_rdata is captured only on a clean ack; instr otherwise holds.

Decomposition:
- Shared package mini_cpu_pkg: enum fetch_state_t (IDLE, FETCH, ISSUE, RESOLVE, HALTED, FAULT), constant PC_STEP=4, INSTR_W=32. The step constant is shared with program_counter.
- Natural sub-module: fetch_timeout, a saturating cycle counter with clear/enable inputs and an expired output, parameterised by TIMEOUT.
- FSM, instruction latch and instret stay in fetch_sequencer.
- The top level connects pc_advance/pc_src to program_counter. Its branch target is pc + imm_branch, so a taken branch with imm=40 at pc=20 gives pc=60.

Test Plan:
- Reset, then zero-wait memory/decode/execute with branch_taken=0: imem_addr sequence 0,4,8,12; one pc_advance every 3 cycles; instret=4 after 4 retires.
- Fetch wait states: ack after 5 cycles -> imem_req held for 5 cycles at a stable imem_addr; instr equals imem_rdata (e.g. 0x00500093); no pc_advance until RESOLVE.
- Backpressure and branch: instr_ready low 3 cycles, then branch_valid=1, branch_taken=1 at pc=68 with target imm -64 -> instr_valid held 3 cycles; single pc_src=1 pulse; next imem_addr=4.
- Timeout and error: no ack for TIMEOUT+1 cycles -> fault=1, imem_req=0 thereafter. Separately, ack with imem_err=1 -> FAULT on the next edge.
- Halt: halt_req=1 during RESOLVE at pc=12 -> pc_advance pulse occurs, halted=1, pc=16 frozen, no further imem_req.
- Reset mid-FETCH and in HALTED: rst=1 -> next edge all outputs 0, instret=0; after release the first imem_addr=0.
